// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus bundle: I-cache request/response, redirect, and decode handshake.
interface if_fetch_queue_if;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic        ICACHE_stall;
    logic [31:0] ICACHE_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    modport master (
        output ICACHE_ren, ICACHE_addr, id_valid, id_instr, id_pc,
        input  ICACHE_stall, ICACHE_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  ICACHE_ren, ICACHE_addr, id_valid, id_instr, id_pc,
        output ICACHE_stall, ICACHE_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads the I-cache one word at a time
// and buffers {instr, pc} pairs in a small FIFO feeding decode.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst_n,
    if_fetch_queue_if.master bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t         state_q;
    logic [31:0]    pc_q;
    logic [31:0]    target_q;
    logic           pending_q;
    logic [CW-1:0]  count_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  wr_ptr_q;
    entry_t         mem_q [DEPTH];

    logic           valid_c;
    logic           pop_c;
    logic           ren_c;
    logic           done_c;
    logic           push_c;
    logic [31:0]    redir_pc_c;
    entry_t         head_c;

    // A stalled request keeps ren high via pending_q, so addr (pc_q) cannot move mid-miss.
    always_comb begin
        valid_c    = (state_q == RUN) && (count_q != '0);
        pop_c      = valid_c && bus.id_ready && !bus.redirect;
        ren_c      = rst_n && ((state_q == DRAIN) || pending_q ||
                               (count_q < CW'(DEPTH)) || (valid_c && bus.id_ready));
        done_c     = ren_c && !bus.ICACHE_stall;
        push_c     = (state_q == RUN) && done_c && !bus.redirect;
        redir_pc_c = bus.redirect_pc & 32'hFFFF_FFFC;
        head_c     = mem_q[rd_ptr_q];
    end

    assign bus.ICACHE_ren  = ren_c;
    assign bus.ICACHE_addr = pc_q[31:2];
    assign bus.id_valid    = valid_c;
    assign bus.id_instr    = head_c.instr;
    assign bus.id_pc       = head_c.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            target_q  <= '0;
            pending_q <= 1'b0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            mem_q     <= '{default: '0};
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.redirect) begin
                        count_q   <= '0;
                        rd_ptr_q  <= '0;
                        wr_ptr_q  <= '0;
                        pending_q <= 1'b0;
                        // A miss in flight must finish at its old address before refetch.
                        if (ren_c && bus.ICACHE_stall) begin
                            target_q <= redir_pc_c;
                            state_q  <= DRAIN;
                        end else begin
                            pc_q <= redir_pc_c;
                        end
                    end else begin
                        pending_q <= ren_c && bus.ICACHE_stall;
                        if (push_c) begin
                            mem_q[wr_ptr_q] <= '{instr: bus.ICACHE_rdata, pc: pc_q};
                            wr_ptr_q        <= wr_ptr_q + 1'b1;
                            pc_q            <= pc_q + 32'd4;
                        end
                        if (pop_c) begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                        if (push_c && !pop_c) begin
                            count_q <= count_q + 1'b1;
                        end else if (!push_c && pop_c) begin
                            count_q <= count_q - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.redirect) begin
                        target_q <= redir_pc_c;
                    end
                    if (!bus.ICACHE_stall) begin
                        pc_q    <= bus.redirect ? redir_pc_c : target_q;
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction fetch stage directly upstream of the decode/immediate-generation logic.
- Owns the fetch PC, issues word reads to the instruction cache, and buffers returned instructions in a small FIFO.
- Presents {instruction, PC} pairs to decode with a valid/ready handshake; supports PC redirect from branch/jump resolution.

Parameters:
DEPTH, 2, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset; word aligned

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ICACHE_ren  out  1  read request to I-cache
ICACHE_addr  out  30  word address, equal to fetch PC[31:2]
ICACHE_stall  in  1  I-cache busy; the request is not complete while high
ICACHE_rdata  in  32  instruction word; valid in a cycle where ren=1 and stall=0
redirect  in  1  one-cycle pulse; flush and restart fetch
redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0
id_ready  in  1  decode accepts the head entry this cycle
id_valid  out  1  queue non-empty
id_instr  out  32  head instruction
id_pc  out  32  PC of head instruction

Behaviour:
- Reset state (asynchronous, rst_n=0):
  - fetch PC = RESET_PC, count = 0, state = RUN, ICACHE_ren = 0.
  - id_valid = 0, id_instr = 0, id_pc = 0.
  - All queue storage is cleared to 0.
- Request completion:
  - A request completes in a cycle where ICACHE_ren=1 and ICACHE_stall=0.
  - ICACHE_rdata is sampled in that same cycle.
  - At most one request is outstanding at any time.
- Cache protocol rule:
  - Once ICACHE_ren is asserted, ren and addr hold stable until completion.
  - They never drop or change mid-miss, including across a redirect.
- Pop: occurs when id_valid && id_ready. The head advances at the clock edge.
- Output path: id_instr and id_pc are driven combinationally from the head entry. There is no extra register stage.
- State RUN:
  - ICACHE_ren = (count < DEPTH) || pop-this-cycle, while no request is mid-flight.
  - Held high while a request is pending.
  - On completion with no redirect:
    - push {rdata, PC} to the queue;
    - PC <= PC + 4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
  - On redirect with no pending incomplete request:
    - flush the queue (count <= 0);
    - PC <= redirect_pc;
    - discard any data completing this cycle;
    - stay in RUN.
  - On redirect while a request is pending (ren=1 and stall=1):
    - flush the queue;
    - latch redirect_pc into a target register;
    - go to DRAIN.
- State DRAIN:
  - Hold ren and the old addr until stall=0.
  - On completion, discard the data, PC <= target, go to RUN.
  - A further redirect in DRAIN overwrites the target; the queue stays empty.
  - id_valid = 0 throughout DRAIN.
- Simultaneous events:
  - redirect has priority over push and pop; nothing is pushed or popped in a redirect cycle.
  - Push and pop in the same cycle leave count unchanged; this is legal when full (count=DEPTH).
  - Pop on empty cannot occur because id_valid=0.
- Counter and pointers:
  - count is log2(DEPTH)+1 bits wide.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
- Latency:
  - With a cache hit (stall=0), the first instruction appears on id_valid one cycle after the completing request.
  - Sustained throughput is 1 instruction/cycle when id_ready=1.
- Reset mid-miss: everything returns to the reset state immediately; the cache sees ren fall asynchronously.

Test Plan:
- Reset then fetch, hit always (stall=0), id_ready=1 -> addresses 0,1,2,... on ICACHE_addr; id_pc = 0,4,8,... one cycle behind; one instruction per cycle.
- Miss: stall high 5 cycles on addr 0x10 -> ren/addr stable all 5 cycles; the instruction is pushed only in the stall=0 cycle; id_valid then rises.
- Backpressure: id_ready=0 -> queue fills to DEPTH=2, ren drops, PC holds; raising id_ready with simultaneous push/pop -> count stays 2 and there are no lost or duplicated PCs.
- Redirect in RUN to 32'h0000_0100 with 2 entries queued -> id_valid=0 next cycle; next ICACHE_addr = 0x40; the first decoded id_pc = 0x100.
- Redirect during a miss (target 0x200) -> DRAIN; old addr held until stall=0; that data is discarded; next addr = 0x80; id_pc = 0x200. A second redirect in DRAIN to 0x300 -> fetch resumes at 0x300.
- rst_n pulsed low mid-miss and at PC 32'hFFFF_FFFC -> outputs zero immediately; fetch restarts at RESET_PC. In a separate run without reset, wrap at 32'hFFFF_FFFC -> next PC = 0.
